// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter from NUM_PORTS core memory ports onto one shared memory port,
// with in-order read-response routing. Define MEM_ARB_QOS_EN to add a per-port priority input.
module mem_port_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int OT_DEPTH   = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_PORTS-1:0]                  port_req_valid,
    input  logic [NUM_PORTS-1:0]                  port_req_write,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  port_req_addr,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  port_req_data,
`ifdef MEM_ARB_QOS_EN
    input  logic [NUM_PORTS-1:0]                  port_req_prio,
`endif
    output logic [NUM_PORTS-1:0]                  port_req_ready,
    output logic [NUM_PORTS-1:0]                  port_resp_valid,
    output logic [DATA_WIDTH-1:0]                 port_resp_data,
    output logic                                  port_resp_last,
    input  logic [NUM_PORTS-1:0]                  port_resp_ready,
    output logic                                  mem_req_valid,
    output logic                                  mem_req_write,
    output logic [ADDR_WIDTH-1:0]                 mem_req_addr,
    output logic [DATA_WIDTH-1:0]                 mem_req_data,
    input  logic                                  mem_req_ready,
    input  logic                                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]                 mem_resp_data,
    input  logic                                  mem_resp_last,
    output logic                                  mem_resp_ready,
    output logic [$clog2(OT_DEPTH+1)-1:0]         outstanding
);

    localparam int PORT_W     = $clog2(NUM_PORTS);
    localparam int OT_W       = $clog2(OT_DEPTH + 1);
    localparam int PTR_W      = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
    localparam int FIFO_SLOTS = 1 << PTR_W;
    localparam logic [OT_W-1:0]   OT_MAX   = OT_W'(OT_DEPTH);
    localparam logic [PORT_W:0]   PORT_CNT = (PORT_W+1)'(NUM_PORTS);
    localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                 state_reg, state_next;
    logic [PORT_W-1:0]      rr_ptr_reg;
    logic                   mem_req_write_reg;
    logic [ADDR_WIDTH-1:0]  mem_req_addr_reg;
    logic [DATA_WIDTH-1:0]  mem_req_data_reg;
    logic [OT_W-1:0]        outstanding_reg, outstanding_next;
    logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [PORT_W-1:0]      fifo_mem [FIFO_SLOTS];

    logic                   read_room;
    logic [NUM_PORTS-1:0]   eligible;
    logic [NUM_PORTS-1:0]   search_vec;
    logic [PORT_W:0]        cand_sum [NUM_PORTS];
    logic [PORT_W-1:0]      cand_idx [NUM_PORTS];
    logic [NUM_PORTS-1:0]   cand_hit;
    logic                   taken [NUM_PORTS];
    logic [PORT_W-1:0]      idx_acc [NUM_PORTS+1];
    logic                   grant_valid;
    logic [PORT_W-1:0]      grant_idx;
    logic                   handshake;
    logic                   push, pop;
    logic                   fifo_empty;
    logic [PORT_W-1:0]      head;

    // Read capacity is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign read_room = (outstanding_reg < OT_MAX);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_elig
            assign eligible[gi] = port_req_valid[gi] && (port_req_write[gi] || read_room);
        end
    endgenerate

`ifdef MEM_ARB_QOS_EN
    logic [NUM_PORTS-1:0] elig_hi;
    assign elig_hi    = eligible & port_req_prio;
    assign search_vec = (|elig_hi) ? elig_hi : eligible;
`else
    assign search_vec = eligible;
`endif

    // Candidate gi is the port gi steps past rr_ptr; the lowest hitting step wins.
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, rr_ptr_reg} + (PORT_W+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= PORT_CNT) ? PORT_W'(cand_sum[gi] - PORT_CNT)
                                                             : cand_sum[gi][PORT_W-1:0];
            assign cand_hit[gi] = search_vec[cand_idx[gi]];
            assign idx_acc[gi+1] = idx_acc[gi]
                                 | ({PORT_W{cand_hit[gi] && !taken[gi]}} & cand_idx[gi]);
        end
        assign taken[0] = 1'b0;
        for (gi = 1; gi < NUM_PORTS; gi++) begin : g_taken
            assign taken[gi] = taken[gi-1] || cand_hit[gi-1];
        end
    endgenerate

    assign idx_acc[0]  = '0;
    assign grant_idx   = idx_acc[NUM_PORTS];
    assign grant_valid = |cand_hit;
    assign handshake   = (state_reg == IDLE) && grant_valid && !reset;

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
            assign port_req_ready[gi] = handshake && (grant_idx == PORT_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (handshake)     state_next = ISSUE;
            ISSUE:   if (mem_req_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            rr_ptr_reg        <= '0;
            mem_req_write_reg <= 1'b0;
            mem_req_addr_reg  <= '0;
            mem_req_data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (handshake) begin
                mem_req_write_reg <= port_req_write[grant_idx];
                mem_req_addr_reg  <= port_req_addr[grant_idx];
                mem_req_data_reg  <= port_req_data[grant_idx];
                rr_ptr_reg        <= (grant_idx == LAST_PORT) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    assign mem_req_valid = (state_reg == ISSUE);
    assign mem_req_write = mem_req_write_reg;
    assign mem_req_addr  = mem_req_addr_reg;
    assign mem_req_data  = mem_req_data_reg;

    // Ordering FIFO: one entry per granted read, holding the issuing port index.
    assign fifo_empty = (outstanding_reg == '0);
    assign head       = fifo_mem[rd_ptr_reg];
    assign push       = handshake && !port_req_write[grant_idx];
    assign pop        = mem_resp_valid && mem_resp_ready && mem_resp_last;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= grant_idx;
        end
    end

    always_comb begin
        outstanding_next = outstanding_reg;
        if (push && !pop) begin
            outstanding_next = outstanding_reg + 1'b1;
        end else if (pop && !push) begin
            outstanding_next = outstanding_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            outstanding_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            outstanding_reg <= outstanding_next;
        end
    end

    assign outstanding = outstanding_reg;

    // With nothing outstanding a response beat is stalled rather than routed anywhere.
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
            assign port_resp_valid[gi] = !reset && !fifo_empty && mem_resp_valid
                                      && (head == PORT_W'(gi));
        end
    endgenerate

    assign mem_resp_ready = !reset && !fifo_empty && port_resp_ready[head];
    assign port_resp_data = mem_resp_data;
    assign port_resp_last = mem_resp_last;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// scored against a queue-based reference model.
module tb_mem_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 48;
    localparam int DW = 64;
    localparam int OT = 4;
    localparam int OW = $clog2(OT + 1);

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NP-1:0]          port_req_valid, port_req_write, port_req_prio;
    logic [NP-1:0][AW-1:0]  port_req_addr;
    logic [NP-1:0][DW-1:0]  port_req_data;
    logic [NP-1:0]          port_req_ready, port_resp_valid, port_resp_ready;
    logic [DW-1:0]          port_resp_data;
    logic                   port_resp_last;
    logic                   mem_req_valid, mem_req_write, mem_req_ready;
    logic [AW-1:0]          mem_req_addr;
    logic [DW-1:0]          mem_req_data;
    logic                   mem_resp_valid, mem_resp_last, mem_resp_ready;
    logic [DW-1:0]          mem_resp_data;
    logic [OW-1:0]          outstanding;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of issuing ports for outstanding reads.
    int             m_q[$];
    bit             m_issue = 1'b0;
    int             m_rr = 0;
    logic           m_w;
    logic [AW-1:0]  m_a;
    logic [DW-1:0]  m_d;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OT_DEPTH(OT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .port_req_valid(port_req_valid),
        .port_req_write(port_req_write),
        .port_req_addr(port_req_addr),
        .port_req_data(port_req_data),
`ifdef MEM_ARB_QOS_EN
        .port_req_prio(port_req_prio),
`endif
        .port_req_ready(port_req_ready),
        .port_resp_valid(port_resp_valid),
        .port_resp_data(port_resp_data),
        .port_resp_last(port_resp_last),
        .port_resp_ready(port_resp_ready),
        .mem_req_valid(mem_req_valid),
        .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data),
        .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data),
        .mem_resp_last(mem_resp_last),
        .mem_resp_ready(mem_resp_ready),
        .outstanding(outstanding)
    );

    // Winner = eligible port closest at or after m_rr in circular distance, high priority first.
    function automatic int model_grant();
        bit elig [NP];
        bit any_hi = 1'b0;
        int best = -1;
        int best_dist = NP;
        if (reset || m_issue) return -1;
        for (int i = 0; i < NP; i++)
            elig[i] = port_req_valid[i] && (port_req_write[i] || m_q.size() < OT);
`ifdef MEM_ARB_QOS_EN
        for (int i = 0; i < NP; i++) if (elig[i] && port_req_prio[i]) any_hi = 1'b1;
        for (int i = 0; i < NP; i++) if (any_hi && !port_req_prio[i]) elig[i] = 1'b0;
`endif
        for (int i = 0; i < NP; i++) begin
            if (elig[i] && ((i - m_rr + NP) % NP) < best_dist) begin
                best = i;
                best_dist = (i - m_rr + NP) % NP;
            end
        end
        return best;
    endfunction

    always @(posedge clk) begin
        int g;
        bit pop;
        g = model_grant();
        if (reset) begin
            m_issue = 1'b0;
            m_rr = 0;
            m_q.delete();
        end else begin
            pop = (m_q.size() > 0) && mem_resp_valid && port_resp_ready[m_q[0]] && mem_resp_last;
            if (pop) void'(m_q.pop_front());
            if (m_issue) begin
                if (mem_req_ready) m_issue = 1'b0;
            end else if (g >= 0) begin
                m_issue = 1'b1;
                m_w = port_req_write[g];
                m_a = port_req_addr[g];
                m_d = port_req_data[g];
                m_rr = (g + 1) % NP;
                if (!m_w) m_q.push_back(g);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        port_req_valid  = '0;
        port_req_write  = '0;
        port_req_prio   = '0;
        port_resp_ready = '0;
        mem_req_ready   = 1'b0;
        mem_resp_valid  = 1'b0;
        mem_resp_last   = 1'b0;
        mem_resp_data   = '0;
        for (int i = 0; i < NP; i++) begin
            port_req_addr[i] = AW'({$urandom, $urandom});
            port_req_data[i] = {$urandom, $urandom};
        end
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if ({mem_req_valid, mem_req_write, port_req_ready, port_resp_valid, mem_resp_ready} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got v=%0b w=%0b rdy=%b rv=%b mrr=%0b want all 0",
                     mem_req_valid, mem_req_write, port_req_ready, port_resp_valid, mem_resp_ready);
        end
        checks++;
        if ({mem_req_addr, mem_req_data, outstanding} !== '0) begin
            errors++;
            $display("FAIL reset_fields got addr=%h data=%h ot=%0d want 0", mem_req_addr, mem_req_data, outstanding);
        end
        $display("reset: checked idle outputs");
        tick();
    endtask

    task automatic test_rr_reads();
        logic [DW-1:0] d;
        apply_reset();
        port_req_valid = '1;
        mem_req_ready  = 1'b1;
        for (int p = 0; p < NP; p++) begin
            @(negedge clk);
            checks++;
            if (port_req_ready !== NP'(1 << p)) begin
                errors++;
                $display("FAIL rr_grant got %b want %b", port_req_ready, NP'(1 << p));
            end
            tick();
            port_req_valid[p] = 1'b0;
            @(negedge clk);
            checks++;
            if ({mem_req_valid, mem_req_write, mem_req_addr, port_req_ready} !== {1'b1, 1'b0, port_req_addr[p], NP'(0)}) begin
                errors++;
                $display("FAIL rr_issue port %0d got v=%0b w=%0b addr=%h rdy=%b want v=1 w=0 addr=%h rdy=0",
                         p, mem_req_valid, mem_req_write, mem_req_addr, port_req_ready, port_req_addr[p]);
            end
            checks++;
            if (outstanding !== OW'(p + 1)) begin
                errors++;
                $display("FAIL rr_outstanding got %0d want %0d", outstanding, p + 1);
            end
            $display("rr read: port %0d issued addr %h", p, port_req_addr[p]);
            tick();
        end
        port_resp_ready = '1;
        for (int p = 0; p < NP; p++) begin
            for (int b = 0; b < 2; b++) begin
                d = DW'(((p + 10) << 4) | b);
                mem_resp_valid = 1'b1;
                mem_resp_data  = d;
                mem_resp_last  = (b == 1);
                @(negedge clk);
                checks++;
                if ({port_resp_valid, mem_resp_ready, port_resp_last, port_resp_data} !== {NP'(1 << p), 1'b1, b == 1, d}) begin
                    errors++;
                    $display("FAIL rr_resp p%0d b%0d got rv=%b mrr=%0b last=%0b data=%h want rv=%b mrr=1 last=%0d data=%h",
                             p, b, port_resp_valid, mem_resp_ready, port_resp_last, port_resp_data, NP'(1 << p), b, d);
                end
                $display("rr resp: beat %0d data %h to port %0d", b, d, p);
                tick();
            end
        end
        mem_resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (outstanding !== OW'(0)) begin
            errors++;
            $display("FAIL rr_drained got %0d want 0", outstanding);
        end
        tick();
    endtask

    task automatic test_full_write_bypass();
        apply_reset();
        mem_req_ready  = 1'b1;
        port_req_valid = 4'b0001;
        for (int k = 0; k < OT; k++) begin
            @(negedge clk);
            checks++;
            if (port_req_ready !== 4'b0001) begin
                errors++;
                $display("FAIL fill_grant %0d got %b want 0001", k, port_req_ready);
            end
            tick();
            if (k == OT - 1) port_req_valid = '0;
            @(negedge clk);
            tick();
        end
        port_req_valid = 4'b0110;
        port_req_write = 4'b0100;
        @(negedge clk);
        checks++;
        if ({outstanding, port_req_ready} !== {OW'(OT), 4'b0100}) begin
            errors++;
            $display("FAIL full_bypass got ot=%0d rdy=%b want ot=4 rdy=0100", outstanding, port_req_ready);
        end
        $display("full: write from port 2 bypasses full FIFO");
        tick();
        port_req_valid[2] = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req_valid, mem_req_write} !== 2'b11) begin
            errors++;
            $display("FAIL full_write_issue got v=%0b w=%0b want 1 1", mem_req_valid, mem_req_write);
        end
        tick();
        @(negedge clk);
        checks++;
        if (port_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL full_block got %b want 0000", port_req_ready);
        end
        tick();
        mem_resp_valid  = 1'b1;
        mem_resp_last   = 1'b1;
        port_resp_ready = 4'b0001;
        @(negedge clk);
        checks++;
        if ({port_resp_valid, mem_resp_ready, port_req_ready} !== {4'b0001, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL full_pop_cycle got rv=%b mrr=%0b rdy=%b want 0001 1 0000",
                     port_resp_valid, mem_resp_ready, port_req_ready);
        end
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({outstanding, port_req_ready} !== {OW'(OT - 1), 4'b0010}) begin
            errors++;
            $display("FAIL full_unblock got ot=%0d rdy=%b want ot=3 rdy=0010", outstanding, port_req_ready);
        end
        $display("full: port 1 read granted after pop");
        tick();
        port_req_valid = '0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_issue_stall();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        apply_reset();
        port_req_valid = 4'b1000;
        port_req_write = 4'b1000;
        a = port_req_addr[3];
        d = port_req_data[3];
        @(negedge clk);
        checks++;
        if (port_req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL stall_grant got %b want 1000", port_req_ready);
        end
        tick();
        port_req_valid = 4'b0001;
        port_req_write = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({mem_req_valid, mem_req_write, mem_req_addr, mem_req_data, port_req_ready} !== {2'b11, a, d, 4'b0000}) begin
                errors++;
                $display("FAIL stall_hold c%0d got v=%0b w=%0b addr=%h data=%h rdy=%b want 1 1 %h %h 0000",
                         c, mem_req_valid, mem_req_write, mem_req_addr, mem_req_data, port_req_ready, a, d);
            end
            tick();
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if ({mem_req_valid, port_req_ready} !== {1'b0, 4'b0001}) begin
            errors++;
            $display("FAIL stall_release got v=%0b rdy=%b want 0 0001", mem_req_valid, port_req_ready);
        end
        $display("stall: write %h held 5 cycles then released", a);
        tick();
        port_req_valid = '0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_resp_backpressure();
        logic [DW-1:0] d;
        apply_reset();
        mem_req_ready  = 1'b1;
        port_req_valid = 4'b0100;
        @(negedge clk);
        tick();
        port_req_valid = '0;
        @(negedge clk);
        tick();
        mem_resp_valid  = 1'b1;
        mem_resp_last   = 1'b0;
        mem_resp_data   = {$urandom, $urandom};
        port_resp_ready = 4'b0100;
        @(negedge clk);
        checks++;
        if ({port_resp_valid, mem_resp_ready} !== {4'b0100, 1'b1}) begin
            errors++;
            $display("FAIL bp_beat0 got rv=%b mrr=%0b want 0100 1", port_resp_valid, mem_resp_ready);
        end
        tick();
        d = {$urandom, $urandom};
        mem_resp_data   = d;
        mem_resp_last   = 1'b1;
        port_resp_ready = 4'b1011;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({port_resp_valid, mem_resp_ready, outstanding} !== {4'b0100, 1'b0, OW'(1)}) begin
                errors++;
                $display("FAIL bp_stall c%0d got rv=%b mrr=%0b ot=%0d want 0100 0 1",
                         c, port_resp_valid, mem_resp_ready, outstanding);
            end
            tick();
        end
        port_resp_ready = 4'b0100;
        @(negedge clk);
        checks++;
        if ({mem_resp_ready, port_resp_last, port_resp_data} !== {2'b11, d}) begin
            errors++;
            $display("FAIL bp_release got mrr=%0b last=%0b data=%h want 1 1 %h",
                     mem_resp_ready, port_resp_last, port_resp_data, d);
        end
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (outstanding !== OW'(0)) begin
            errors++;
            $display("FAIL bp_pop got %0d want 0", outstanding);
        end
        $display("backpressure: port 2 last beat %h delivered after stall", d);
        tick();
    endtask

    task automatic test_stray_resp();
        apply_reset();
        mem_resp_valid  = 1'b1;
        mem_resp_last   = 1'b1;
        port_resp_ready = '1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({mem_resp_ready, port_resp_valid, outstanding} !== '0) begin
                errors++;
                $display("FAIL stray c%0d got mrr=%0b rv=%b ot=%0d want 0 0000 0",
                         c, mem_resp_ready, port_resp_valid, outstanding);
            end
            tick();
        end
        mem_resp_valid = 1'b0;
        $display("stray: response stalled with empty FIFO");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mem_req_ready  = 1'b1;
        port_req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tick();
            port_req_valid[k] = 1'b0;
            if (k == 2) mem_req_ready = 1'b0;
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        checks++;
        if ({mem_req_valid, outstanding} !== {1'b1, OW'(3)}) begin
            errors++;
            $display("FAIL mid_pre got v=%0b ot=%0d want 1 3", mem_req_valid, outstanding);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        port_req_valid = '1;
        mem_req_ready  = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req_valid, outstanding, port_req_ready} !== {1'b0, OW'(0), 4'b0001}) begin
            errors++;
            $display("FAIL mid_reset got v=%0b ot=%0d rdy=%b want 0 0 0001",
                     mem_req_valid, outstanding, port_req_ready);
        end
        $display("mid reset: held request and 3 reads discarded");
        tick();
        port_req_valid = '0;
        @(negedge clk);
        tick();
    endtask

`ifdef MEM_ARB_QOS_EN
    task automatic test_qos();
        apply_reset();
        mem_req_ready  = 1'b1;
        port_req_valid = 4'b1001;
        port_req_write = 4'b1001;
        port_req_prio  = 4'b1000;
        @(negedge clk);
        checks++;
        if (port_req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL qos_first got %b want 1000", port_req_ready);
        end
        tick();
        port_req_valid[3] = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if (port_req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL qos_second got %b want 0001", port_req_ready);
        end
        $display("qos: port 3 high priority granted before port 0");
        tick();
        port_req_valid = '0;
        @(negedge clk);
        tick();
    endtask
`endif

    task automatic test_random();
        int g;
        int grants = 0;
        logic [NP-1:0] exp_ready, exp_rv;
        logic exp_mrr;
        apply_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            port_req_valid  = NP'($urandom);
            port_req_write  = NP'($urandom);
            port_req_prio   = NP'($urandom);
            for (int i = 0; i < NP; i++) begin
                port_req_addr[i] = AW'({$urandom, $urandom});
                port_req_data[i] = {$urandom, $urandom};
            end
            mem_req_ready   = ($urandom_range(3) != 0);
            mem_resp_valid  = $urandom_range(1) == 1;
            mem_resp_last   = $urandom_range(1) == 1;
            mem_resp_data   = {$urandom, $urandom};
            port_resp_ready = NP'($urandom);
            @(negedge clk);
            g = model_grant();
            exp_ready = '0;
            if (g >= 0) begin
                exp_ready[g] = 1'b1;
                grants++;
            end
            exp_rv  = '0;
            exp_mrr = 1'b0;
            if (m_q.size() > 0) begin
                exp_rv[m_q[0]] = mem_resp_valid;
                exp_mrr = port_resp_ready[m_q[0]];
            end
            checks++;
            if (port_req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rnd_grant cyc %0d got %b want %b", cyc, port_req_ready, exp_ready);
            end
            checks++;
            if (mem_req_valid !== m_issue) begin
                errors++;
                $display("FAIL rnd_mem_valid cyc %0d got %0b want %0b", cyc, mem_req_valid, m_issue);
            end else if (m_issue) begin
                checks++;
                if ({mem_req_write, mem_req_addr, mem_req_data} !== {m_w, m_a, m_d}) begin
                    errors++;
                    $display("FAIL rnd_mem_fields cyc %0d got w=%0b a=%h d=%h want w=%0b a=%h d=%h",
                             cyc, mem_req_write, mem_req_addr, mem_req_data, m_w, m_a, m_d);
                end
            end
            checks++;
            if (outstanding !== OW'(m_q.size())) begin
                errors++;
                $display("FAIL rnd_outstanding cyc %0d got %0d want %0d", cyc, outstanding, m_q.size());
            end
            checks++;
            if ({port_resp_valid, mem_resp_ready} !== {exp_rv, exp_mrr}) begin
                errors++;
                $display("FAIL rnd_route cyc %0d got rv=%b mrr=%0b want rv=%b mrr=%0b",
                         cyc, port_resp_valid, mem_resp_ready, exp_rv, exp_mrr);
            end
            if (exp_rv != '0) begin
                checks++;
                if ({port_resp_data, port_resp_last} !== {mem_resp_data, mem_resp_last}) begin
                    errors++;
                    $display("FAIL rnd_resp_data cyc %0d got %h/%0b want %h/%0b",
                             cyc, port_resp_data, port_resp_last, mem_resp_data, mem_resp_last);
                end
            end
            tick();
        end
        $display("random: 2000 cycles, %0d grants scored", grants);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_rr_reads();
        test_full_write_bypass();
        test_issue_stall();
        test_resp_backpressure();
        test_stray_resp();
        test_reset_mid();
`ifdef MEM_ARB_QOS_EN
        test_qos();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- N-port request arbiter and response router between per-core network-interface memory ports and the single shared memory interface of the multicore system.
- Parametrised successor to the fixed single-requester memory hookup:
  - generalised port count, address width and data width;
  - round-robin fairness;
  - in-order tracking of outstanding reads;
  - multi-beat read responses routed back to the issuing port.

Parameters:
- NUM_PORTS, 4, number of requesting ports (>=2)
- ADDR_WIDTH, 48, request address width
- DATA_WIDTH, 64, request/response data width
- OT_DEPTH, 4, max outstanding reads (ordering FIFO depth, power of 2)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- port_req_valid  in  NUM_PORTS  per-port request valid
- port_req_write  in  NUM_PORTS  1=write, 0=read
- port_req_addr  in  NUM_PORTS x ADDR_WIDTH  per-port address
- port_req_data  in  NUM_PORTS x DATA_WIDTH  per-port write data
- port_req_ready  out  NUM_PORTS  per-port accept (one-hot or zero)
- port_resp_valid  out  NUM_PORTS  response valid to owning port (one-hot or zero)
- port_resp_data  out  DATA_WIDTH  shared response data
- port_resp_last  out  1  final beat of response
- port_resp_ready  in  NUM_PORTS  per-port response accept
- mem_req_valid  out  1  memory request valid
- mem_req_write  out  1  memory request type
- mem_req_addr  out  ADDR_WIDTH  memory address
- mem_req_data  out  DATA_WIDTH  memory write data
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  memory response beat valid
- mem_resp_data  in  DATA_WIDTH  response beat data
- mem_resp_last  in  1  last beat of read response
- mem_resp_ready  out  1  arbiter accepts beat
- outstanding  out  clog2(OT_DEPTH+1)  reads granted but not completed

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, rr_ptr=0, FIFO empty, outstanding=0.
  - All valid/ready outputs 0; mem_req_addr/data/write 0.
  - Mid-operation reset discards the held request and all FIFO entries. The memory side is reset in the same cycle.
- Request FSM:
  - IDLE:
    - Eligible port i = port_req_valid[i] && (port_req_write[i] || outstanding<OT_DEPTH), with outstanding taken from the registered value.
    - Grant goes to the first eligible port searching from rr_ptr upward, with wrap-around.
    - port_req_ready is asserted combinationally for the granted port only.
    - On handshake: latch write/addr/data and the port index; rr_ptr <= grant+1 mod NUM_PORTS; go to ISSUE.
    - A read pushes the port index into the ordering FIFO in the same cycle.
  - ISSUE:
    - mem_req_valid=1 with fields stable.
    - All port_req_ready=0.
    - On mem_req_ready, go to IDLE.
  - Latency: port handshake at cycle t -> mem_req_valid at t+1. Max throughput is one request per 2 cycles.
- Writes produce no response and are never blocked by the FIFO.
- Response routing:
  - head = FIFO head port index.
  - When the FIFO is not empty: port_resp_valid[head] = mem_resp_valid; port_resp_data/last pass through combinationally; mem_resp_ready = port_resp_ready[head].
  - When the FIFO is empty: all port_resp_valid=0 and mem_resp_ready=0. A stray response is stalled, never dropped or misrouted.
  - A beat transfers on mem_resp_valid && mem_resp_ready. The FIFO pops on a transferred beat with mem_resp_last=1.
  - Multi-beat bursts stay on the same port until last. Non-last beats do not change head.
- outstanding: +1 on a read grant, -1 on a last-beat pop, unchanged when both happen in the same cycle.
- Full: outstanding==OT_DEPTH blocks read grants. A pop in that same cycle does not unblock until the next cycle.
- Empty: no response routing.

Optional Feature:
- MEM_ARB_QOS_EN defined:
  - Adds input port_req_prio (NUM_PORTS, 1 bit per port).
  - Eligible high-priority ports win over low-priority ports.
  - Round-robin from rr_ptr applies within each level; rr_ptr advances past the grant as usual.
- Not defined: port absent, pure round-robin.

Test Plan:
- Ports 0-3 all request reads simultaneously from rr_ptr=0 (OT_DEPTH=4, mem_req_ready=1) -> grants in order 0,1,2,3, one every 2 cycles, outstanding=4. Responses of 2 beats each (data A0,A1..D0,D1) go to ports 0,1,2,3 in order, last on the 2nd beat.
- outstanding=4, port 1 read pending, port 2 write pending -> port 2 write granted, port 1 blocked. After one last-beat pop, port 1 is granted the following cycle.
- mem_req_ready held 0 for 5 cycles in ISSUE -> mem_req_valid stays 1 with addr/data stable and no new port_req_ready. Release -> IDLE.
- Response for port 2, beat 1, with port_resp_ready[2]=0 for 3 cycles -> mem_resp_ready=0, no pop. Ready=1 -> beat transfers and the FIFO pops on last.
- mem_resp_valid=1 with FIFO empty -> mem_resp_ready=0 and all port_resp_valid=0.
- reset asserted while in ISSUE with 3 reads outstanding -> next cycle mem_req_valid=0, outstanding=0, rr_ptr=0.
- (MEM_ARB_QOS_EN) ports 0 and 3 request with prio[3]=1 -> port 3 granted first.
